// File: rtl/cvp_mem_responder_if.sv
// CVP14 processor-to-memory bus: word address, read/write strobes,
// write data toward memory, read data plus strobe and error back.
interface cvp_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic              WR;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              DValid;
    logic              Err;

    // Processor side
    modport master (
        output Addr, RD, WR, DataIn,
        input  DataOut, DValid, Err
    );

    // Memory side
    modport slave (
        input  Addr, RD, WR, DataIn,
        output DataOut, DValid, Err
    );
endinterface

// File: rtl/cvp_mem_responder.sv
// Memory-side responder for the CVP14 bus: word-addressed backing array,
// fixed-latency pipelined reads with a DValid strobe, sticky error flag for
// simultaneous RD/WR and out-of-range addresses.
module cvp_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                 Clk1,
    input  logic                 Reset,
    cvp_mem_responder_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("cvp_mem_responder: RD_LAT must be in 1..4");
        end
    endgenerate

    // Full-width comparison so high address bits are never silently dropped.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    // Backing array; deliberately not reset so contents survive Reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Request decode (p0: the sampling edge)
    logic              in_range_p0;
    logic              illegal_p0;
    logic              rd_acc_p0;
    logic              wr_acc_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic [DATA_W-1:0] rdata_p0;

    // Read pipeline: stage RD_LAT-1 is the output register. Its data entry
    // only loads on a valid result, so DataOut holds between strobes.
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] dat_p [RD_LAT];
    logic [RD_LAT-1:0] vld_in;
    logic [DATA_W-1:0] dat_in [RD_LAT];

    logic err_q;

    // Classify the sampled request and fetch the read word (read-first).
    always_comb begin
        in_range_p0 = addr_in_range(bus.Addr);
        illegal_p0  = bus.RD & bus.WR;
        rd_acc_p0   = bus.RD & ~bus.WR;
        wr_acc_p0   = bus.WR & ~bus.RD & in_range_p0;
        idx_p0      = in_range_p0 ? bus.Addr[IDX_W-1:0] : '0;
        rdata_p0    = in_range_p0 ? mem[idx_p0] : '0;
    end

    // Array write port; requests seen during Reset are ignored.
    always_ff @(posedge Clk1) begin
        if (!Reset && wr_acc_p0) begin
            mem[idx_p0] <= bus.DataIn;
        end
    end

    // Build each stage's input from the previous stage (stage 0 from decode).
    always_comb begin
        vld_in    = '0;
        vld_in[0] = rd_acc_p0;
        dat_in[0] = rdata_p0;
        for (int s = 1; s < RD_LAT; s++) begin
            vld_in[s] = vld_p[s-1];
            dat_in[s] = dat_p[s-1];
        end
    end

    // Valid shift chain; Reset discards every in-flight read.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            vld_p <= '0;
        end else begin
            vld_p <= vld_in;
        end
    end

    // Data shift chain; only the output stage is reset and it loads on valid.
    always_ff @(posedge Clk1) begin
        for (int s = 0; s < RD_LAT; s++) begin
            if (s == RD_LAT - 1) begin
                if (Reset) begin
                    dat_p[s] <= '0;
                end else if (vld_in[s]) begin
                    dat_p[s] <= dat_in[s];
                end
            end else begin
                dat_p[s] <= dat_in[s];
            end
        end
    end

    // Sticky error: simultaneous RD/WR or any access outside the array.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (illegal_p0 || ((bus.RD || bus.WR) && !in_range_p0)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.DataOut = dat_p[RD_LAT-1];
    assign bus.DValid  = vld_p[RD_LAT-1];
    assign bus.Err     = err_q;

endmodule

// File: tb/tb_cvp_mem_responder.sv
// Bench for cvp_mem_responder: table of bus cycles with expected Err, a
// reference model that queues expected read results, and hand sequences
// for reset-during-read and random read/write interleaving.
module tb_cvp_mem_responder;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cvp_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cvp_mem_responder #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT)
    ) dut (
        .Clk1  (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          r;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          exp_err;
    } vec_t;

    exp_t          sbq[$];
    vec_t          tbl[$];
    logic [DW-1:0] mmem [DEPTH];
    logic          merr;
    logic [DW-1:0] mlast;
    int            cyc;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.addr = a; v.din = d; v.exp_err = e;
        tbl.push_back(v);
    endtask

    // One bus cycle: drive, clock, update model, then compare outputs.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        rst        = r;
        bus.RD     = rd;
        bus.WR     = wr;
        bus.Addr   = a;
        bus.DataIn = d;
        @(posedge clk);
        if (r) begin
            sbq.delete();
            merr  = 1'b0;
            mlast = '0;
        end else if (rd && wr) begin
            merr = 1'b1;
        end else if (rd) begin
            e.due  = cyc + LAT;
            e.data = (int'(a) < DEPTH) ? mmem[a[9:0]] : '0;
            sbq.push_back(e);
            if (int'(a) >= DEPTH) merr = 1'b1;
        end else if (wr) begin
            if (int'(a) < DEPTH) mmem[a[9:0]] = d;
            else merr = 1'b1;
        end
        cyc++;
        #1;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            mlast = e.data;
            chk("dvalid_hi", 32'(bus.DValid), 32'd1);
        end else begin
            chk("dvalid_lo", 32'(bus.DValid), 32'd0);
        end
        chk("dataout", 32'(bus.DataOut), 32'(mlast));
        chk("err", 32'(bus.Err), 32'(merr));
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            op;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        merr       = 1'b0;
        mlast      = '0;
        rst        = 1'b1;
        bus.RD     = 1'b0;
        bus.WR     = 1'b0;
        bus.Addr   = '0;
        bus.DataIn = '0;

        // reset, idle, write/read, pipelined reads, read-first, illegal, out of range
        add(1, 0, 0, 16'h0000, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 1, 16'h0010, 16'hBEEF, 0);
        add(0, 1, 0, 16'h0010, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 1, 16'h0011, 16'h00A1, 0);
        add(0, 0, 1, 16'h0012, 16'h00A2, 0);
        add(0, 0, 1, 16'h0013, 16'h00A3, 0);
        add(0, 1, 0, 16'h0011, 16'h0000, 0);
        add(0, 1, 0, 16'h0012, 16'h0000, 0);
        add(0, 1, 0, 16'h0013, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 1, 16'h0020, 16'h1111, 0);
        add(0, 1, 0, 16'h0020, 16'h0000, 0);
        add(0, 0, 1, 16'h0020, 16'h2222, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 1, 0, 16'h0020, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 1, 16'h0005, 16'h0000, 0);
        add(0, 1, 1, 16'h0005, 16'h5555, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1);
        add(0, 1, 0, 16'h0005, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 1, 0, 16'h0400, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 1, 16'h0400, 16'h7777, 1);
        add(1, 0, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 16'h0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
            chk("tbl_err", 32'(bus.Err), 32'(tbl[i].exp_err));
        end

        // read followed by reset: the read must never strobe
        step(0, 1, 0, 16'h0010, 16'h0000);
        step(1, 0, 0, 16'h0000, 16'h0000);
        step(0, 0, 0, 16'h0000, 16'h0000);
        chk("rst_drop_dv", 32'(bus.DValid), 32'd0);
        chk("rst_drop_do", 32'(bus.DataOut), 32'h0000);

        // array contents survive reset
        step(0, 1, 0, 16'h0010, 16'h0000);
        for (int i = 1; i < LAT; i++) step(0, 0, 0, 16'h0000, 16'h0000);
        chk("persist_dv", 32'(bus.DValid), 32'd1);
        chk("persist_do", 32'(bus.DataOut), 32'hBEEF);

        // random interleaved reads/writes over a small window
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 16'(16'h0100 + i), 16'($urandom));
        end
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            ra = 16'(16'h0100 + $urandom_range(0, 15));
            if (op < 4)      step(0, 1, 0, ra, 16'h0000);
            else if (op < 8) step(0, 0, 1, ra, 16'($urandom));
            else             step(0, 0, 0, ra, 16'h0000);
        end
        for (int i = 0; i <= LAT; i++) step(0, 0, 0, 16'h0000, 16'h0000);
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
